jtag_dap_multi: RTL and testbench
=================================

Name: jtag_dap_multi

Overview:
- Parametrised successor of the current debug access port.
- Contains a full IEEE 1149.1 TAP state machine, an IR of configurable width, a built-in IDCODE register and a BYPASS register.
- Adds NUM_DR user data-register channels, each with a parallel capture input and an update output plus strobe.
- Sits between the board JTAG pins and on-chip debug/boundary logic. All logic runs on TCK; there is no separate internal clock.

Parameters:
- IR_WIDTH, 5, instruction register width in bits (≥3).
- NUM_DR, 4, number of user DR channels (1..8).
- DR_WIDTH, 32, width of each user DR.
- IDCODE_VAL, 32'h1000_0003, value captured by IDCODE; bit 0 must be 1.
- IDCODE_OP, 1, IDCODE opcode.
- USER_BASE, 8, opcode of user channel 0; channel k uses USER_BASE+k. Range must not overlap IDCODE_OP or the all-ones opcode.

Ports:
- TCK, in, 1, sole clock; all state changes on the rising edge.
- TRST, in, 1, reset, synchronous, active-low.
- TMS, in, 1, TAP mode select.
- TDI, in, 1, serial data in.
- TDO, out, 1, serial data out.
- tdo_en, out, 1, high while in Shift-IR or Shift-DR.
- state_out, out, 4, current TAP state code.
- ir_out, out, IR_WIDTH, current instruction.
- dr_select, out, NUM_DR, one-hot active user channel; all zero if ir_out is not a user opcode.
- dr_capture_data, in, NUM_DR*DR_WIDTH, parallel capture data; channel k occupies bits [k*DR_WIDTH +: DR_WIDTH].
- dr_update_data, out, NUM_DR*DR_WIDTH, parallel update registers, same packing.
- dr_update_pulse, out, NUM_DR, one-cycle update strobe per channel.

Behaviour:
- Reset:
  - TRST=0 at a rising TCK edge sets state to Test-Logic-Reset (TLR), ir_out=IDCODE_OP, all shift registers to 0, dr_update_data to 0 and dr_update_pulse to 0.
  - Reset has priority over TMS and over any operation in progress.
- State codes (standard 16-state FSM, transitions on TMS per 1149.1):
  - TLR F, RTI C
  - Select-DR 7, Capture-DR 6, Shift-DR 2, Exit1-DR 1, Pause-DR 3, Exit2-DR 0, Update-DR 5
  - Select-IR 4, Capture-IR E, Shift-IR A, Exit1-IR 9, Pause-IR B, Exit2-IR 8, Update-IR D
- Five consecutive TMS=1 edges reach TLR from any state. Every edge taken while in TLR reloads ir_out=IDCODE_OP.
- Action rule: an action for state S executes on the rising edge taken while the current state is S.
- IR path:
  - Capture-IR: IR shift register loads {0…0,2'b01}.
  - Shift-IR: shift right, TDI enters the MSB.
  - Update-IR: ir_out takes the shift register value.
  - Exit/Pause states hold the shift register contents.
- DR decode from ir_out:
  - IDCODE_OP selects the 32-bit IDCODE register.
  - USER_BASE+k, for k<NUM_DR, selects user channel k.
  - Any other opcode, including all-ones, selects BYPASS.
- Capture-DR loads:
  - IDCODE: IDCODE_VAL.
  - BYPASS: 0.
  - User channel k: that channel's slice of dr_capture_data.
- Shift-DR: the selected register shifts right, TDI enters its MSB. Unselected registers hold.
- TDO:
  - Combinational: bit 0 of the IR shift register in Shift-IR, bit 0 of the selected DR in Shift-DR, 0 otherwise.
  - Consequence: BYPASS adds exactly one TCK of delay from TDI to TDO.
- Update-DR on user channel k:
  - The edge loads that channel's dr_update_data slice from its shift register.
  - dr_update_pulse[k] is 1 for exactly the following cycle.
  - Other channels are unaffected.
- Update-DR on IDCODE or BYPASS: no outputs change.
- Instruction change: a new instruction takes effect only at Update-IR. A DR shift begun under the old instruction completes with the old selection.
- Reset during a shift: shift data is discarded and dr_update_data is cleared.
- Entering TLR via TMS alone (TRST high): resets the IR only. dr_update_data is preserved.

Test Plan:
- Reset and IDCODE read: TRST=0 for 1 edge, then TLR→RTI→Shift-DR, 32 shifts → TDO emits 32'h1000_0003 LSB-first; state_out=2 while shifting.
- IR capture: go to Shift-IR, shift 5 bits with TDI=1 → TDO=1,0,0,0,0; after Update-IR, ir_out=5'h1F (BYPASS).
- BYPASS: select BYPASS, Shift-DR with TDI pattern 1,0,1,1 → TDO=0,1,0,1.
- User channel: IR=USER_BASE+2, drive capture slice 2 = 32'hDEAD_BEEF, shift in 32'h1234_5678 → TDO emits DEAD_BEEF LSB-first; after Update-DR, slice 2 of dr_update_data = 32'h1234_5678, dr_update_pulse=4'b0100 for one cycle, dr_select=4'b0100.
- Unknown opcode: IR=5'h03 → acts as BYPASS (1-bit delay) and dr_select=0.
- Reset cases:
  - TRST=0 mid Shift-DR on channel 1 → state_out=F, ir_out=1, all dr_update_data=0.
  - Separately, with TRST high, five TMS=1 edges from Pause-DR → state_out=F, dr_update_data retained.

Source files
------------

// File: rtl/jtag_dap_multi.sv
// jtag_dap_multi: IEEE 1149.1 TAP controller with an IR, a built-in IDCODE
// register, a BYPASS register and NUM_DR user data-register channels.
// All logic runs on TCK. TRST is a synchronous, active-low reset.
//
// Ports:
//   TCK             - sole clock, rising-edge active
//   TRST            - synchronous active-low reset
//   TMS, TDI        - TAP mode select / serial data in
//   TDO             - serial data out (combinational from current state)
//   tdo_en          - high in Shift-IR or Shift-DR
//   state_out       - current TAP state code
//   ir_out          - current (updated) instruction
//   dr_select       - one-hot active user channel, zero for non-user opcodes
//   dr_capture_data - parallel capture data, channel k at [k*DR_WIDTH +: DR_WIDTH]
//   dr_update_data  - parallel update registers, same packing
//   dr_update_pulse - one-cycle strobe per channel following its Update-DR
module jtag_dap_multi #(
  parameter int unsigned IR_WIDTH   = 5,
  parameter int unsigned NUM_DR     = 4,
  parameter int unsigned DR_WIDTH   = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0003,
  parameter int unsigned IDCODE_OP  = 1,
  parameter int unsigned USER_BASE  = 8
) (
  input  logic                         TCK,
  input  logic                         TRST,
  input  logic                         TMS,
  input  logic                         TDI,
  output logic                         TDO,
  output logic                         tdo_en,
  output logic [3:0]                   state_out,
  output logic [IR_WIDTH-1:0]          ir_out,
  output logic [NUM_DR-1:0]            dr_select,
  input  logic [NUM_DR*DR_WIDTH-1:0]   dr_capture_data,
  output logic [NUM_DR*DR_WIDTH-1:0]   dr_update_data,
  output logic [NUM_DR-1:0]            dr_update_pulse
);

  localparam int unsigned IDCODE_W = 32;

  typedef enum logic [3:0] {
    S_EXIT2_DR   = 4'h0,
    S_EXIT1_DR   = 4'h1,
    S_SHIFT_DR   = 4'h2,
    S_PAUSE_DR   = 4'h3,
    S_SELECT_IR  = 4'h4,
    S_UPDATE_DR  = 4'h5,
    S_CAPTURE_DR = 4'h6,
    S_SELECT_DR  = 4'h7,
    S_EXIT2_IR   = 4'h8,
    S_EXIT1_IR   = 4'h9,
    S_SHIFT_IR   = 4'hA,
    S_PAUSE_IR   = 4'hB,
    S_RTI        = 4'hC,
    S_UPDATE_IR  = 4'hD,
    S_CAPTURE_IR = 4'hE,
    S_TLR        = 4'hF
  } tap_state_t;

  tap_state_t                  r_state;
  tap_state_t                  w_state_nxt;

  logic [IR_WIDTH-1:0]         r_ir;
  logic [IR_WIDTH-1:0]         r_ir_sr;
  logic                        r_bypass;
  logic [IDCODE_W-1:0]         r_idcode_sr;
  logic [DR_WIDTH-1:0]         r_user_sr [NUM_DR];
  logic [NUM_DR*DR_WIDTH-1:0]  r_upd_data;
  logic [NUM_DR-1:0]           r_upd_pulse;

  logic                        w_sel_idcode;
  logic                        w_sel_bypass;
  logic [NUM_DR-1:0]           w_sel_user;
  logic                        w_dr_tdo;
  logic [IR_WIDTH-1:0]         w_ir_capture;

  // IR capture pattern: fixed 2'b01 in the low bits, zeros above
  assign w_ir_capture = {{(IR_WIDTH-2){1'b0}}, 2'b01};

  // TAP state register
  always_ff @(posedge TCK) begin
    if (!TRST) begin
      r_state <= S_TLR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // TAP next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_TLR:        w_state_nxt = TMS ? S_TLR       : S_RTI;
      S_RTI:        w_state_nxt = TMS ? S_SELECT_DR : S_RTI;
      S_SELECT_DR:  w_state_nxt = TMS ? S_SELECT_IR : S_CAPTURE_DR;
      S_CAPTURE_DR: w_state_nxt = TMS ? S_EXIT1_DR  : S_SHIFT_DR;
      S_SHIFT_DR:   w_state_nxt = TMS ? S_EXIT1_DR  : S_SHIFT_DR;
      S_EXIT1_DR:   w_state_nxt = TMS ? S_UPDATE_DR : S_PAUSE_DR;
      S_PAUSE_DR:   w_state_nxt = TMS ? S_EXIT2_DR  : S_PAUSE_DR;
      S_EXIT2_DR:   w_state_nxt = TMS ? S_UPDATE_DR : S_SHIFT_DR;
      S_UPDATE_DR:  w_state_nxt = TMS ? S_SELECT_DR : S_RTI;
      S_SELECT_IR:  w_state_nxt = TMS ? S_TLR       : S_CAPTURE_IR;
      S_CAPTURE_IR: w_state_nxt = TMS ? S_EXIT1_IR  : S_SHIFT_IR;
      S_SHIFT_IR:   w_state_nxt = TMS ? S_EXIT1_IR  : S_SHIFT_IR;
      S_EXIT1_IR:   w_state_nxt = TMS ? S_UPDATE_IR : S_PAUSE_IR;
      S_PAUSE_IR:   w_state_nxt = TMS ? S_EXIT2_IR  : S_PAUSE_IR;
      S_EXIT2_IR:   w_state_nxt = TMS ? S_UPDATE_IR : S_SHIFT_IR;
      S_UPDATE_IR:  w_state_nxt = TMS ? S_SELECT_DR : S_RTI;
      default:      w_state_nxt = S_TLR;
    endcase
  end

  // DR decode from the updated instruction; IDCODE wins, unmatched -> BYPASS
  always_comb begin
    w_sel_idcode = (r_ir == IR_WIDTH'(IDCODE_OP));
    w_sel_user   = '0;
    for (int k = 0; k < int'(NUM_DR); k++) begin
      if (!w_sel_idcode && (r_ir == IR_WIDTH'(USER_BASE + 32'(k)))) begin
        w_sel_user[k] = 1'b1;
      end
    end
    w_sel_bypass = !w_sel_idcode && (w_sel_user == '0);
  end

  // Serial output bit of whichever DR is selected
  always_comb begin
    w_dr_tdo = (w_sel_idcode & r_idcode_sr[0]) | (w_sel_bypass & r_bypass);
    for (int k = 0; k < int'(NUM_DR); k++) begin
      w_dr_tdo = w_dr_tdo | (w_sel_user[k] & r_user_sr[k][0]);
    end
  end

  // Per-state actions execute on the edge taken while in that state.
  // TLR reached through TMS reloads only the instruction; the update
  // registers are cleared by TRST alone.
  always_ff @(posedge TCK) begin
    if (!TRST) begin
      r_ir        <= IR_WIDTH'(IDCODE_OP);
      r_ir_sr     <= '0;
      r_bypass    <= 1'b0;
      r_idcode_sr <= '0;
      for (int k = 0; k < int'(NUM_DR); k++) begin
        r_user_sr[k] <= '0;
      end
      r_upd_data  <= '0;
      r_upd_pulse <= '0;
    end else begin
      r_upd_pulse <= '0;
      case (r_state)
        S_TLR: begin
          r_ir <= IR_WIDTH'(IDCODE_OP);
        end
        S_CAPTURE_IR: begin
          r_ir_sr <= w_ir_capture;
        end
        S_SHIFT_IR: begin
          r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
        end
        S_UPDATE_IR: begin
          r_ir <= r_ir_sr;
        end
        S_CAPTURE_DR: begin
          if (w_sel_idcode) r_idcode_sr <= IDCODE_VAL;
          if (w_sel_bypass) r_bypass    <= 1'b0;
          for (int k = 0; k < int'(NUM_DR); k++) begin
            if (w_sel_user[k]) begin
              r_user_sr[k] <= dr_capture_data[k*DR_WIDTH +: DR_WIDTH];
            end
          end
        end
        S_SHIFT_DR: begin
          if (w_sel_idcode) r_idcode_sr <= {TDI, r_idcode_sr[IDCODE_W-1:1]};
          if (w_sel_bypass) r_bypass    <= TDI;
          for (int k = 0; k < int'(NUM_DR); k++) begin
            if (w_sel_user[k]) begin
              r_user_sr[k] <= {TDI, r_user_sr[k][DR_WIDTH-1:1]};
            end
          end
        end
        S_UPDATE_DR: begin
          // IDCODE and BYPASS have no parallel outputs to update
          for (int k = 0; k < int'(NUM_DR); k++) begin
            if (w_sel_user[k]) begin
              r_upd_data[k*DR_WIDTH +: DR_WIDTH] <= r_user_sr[k];
              r_upd_pulse[k]                     <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tdo_en          = (r_state == S_SHIFT_IR) || (r_state == S_SHIFT_DR);
  assign TDO             = (r_state == S_SHIFT_IR) ? r_ir_sr[0] :
                           (r_state == S_SHIFT_DR) ? w_dr_tdo   : 1'b0;
  assign state_out       = r_state;
  assign ir_out          = r_ir;
  assign dr_select       = w_sel_user;
  assign dr_update_data  = r_upd_data;
  assign dr_update_pulse = r_upd_pulse;

endmodule

// File: tb/tb_jtag_dap_multi.sv
// Self-checking bench for jtag_dap_multi: expected TDO bits are queued as
// each shift is set up and popped as the DUT shifts them out; update
// registers are checked against a bench-side copy.
module tb_jtag_dap_multi;

  localparam int unsigned IR_W  = 5;
  localparam int unsigned N_DR  = 4;
  localparam int unsigned DR_W  = 32;
  localparam logic [31:0] IDC   = 32'h1000_0003;
  localparam int unsigned ID_OP = 1;
  localparam int unsigned UB    = 8;

  logic                     TCK  = 1'b0;
  logic                     TRST = 1'b1;
  logic                     TMS  = 1'b1;
  logic                     TDI  = 1'b0;
  logic                     TDO;
  logic                     tdo_en;
  logic [3:0]               state_out;
  logic [IR_W-1:0]          ir_out;
  logic [N_DR-1:0]          dr_select;
  logic [N_DR*DR_W-1:0]     cap;
  logic [N_DR*DR_W-1:0]     dr_update_data;
  logic [N_DR-1:0]          dr_update_pulse;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_q[$];
  logic [N_DR*DR_W-1:0] exp_upd;

  jtag_dap_multi #(
    .IR_WIDTH(IR_W), .NUM_DR(N_DR), .DR_WIDTH(DR_W),
    .IDCODE_VAL(IDC), .IDCODE_OP(ID_OP), .USER_BASE(UB)
  ) u_dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .tdo_en(tdo_en), .state_out(state_out), .ir_out(ir_out),
    .dr_select(dr_select), .dr_capture_data(cap),
    .dr_update_data(dr_update_data), .dr_update_pulse(dr_update_pulse)
  );

  always #5 TCK = ~TCK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive TMS/TDI, take one rising edge, return at the following falling edge
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
  endtask

  // Shift n bits from Shift-xR; TDO is sampled before each edge
  task automatic shift_bits(input string tag, input logic [31:0] din, input int n,
                            input logic [31:0] dexp, input bit last_exit);
    logic e;
    for (int i = 0; i < n; i++) exp_q.push_back(dexp[i]);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: scoreboard empty at bit %0d", tag, i);
        e = 1'b0;
      end else begin
        e = exp_q.pop_front();
      end
      check($sformatf("%s[%0d]", tag, i), 128'(TDO), 128'(e));
      step(last_exit && (i == n - 1), din[i]);
    end
  endtask

  task automatic goto_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic goto_shift_ir();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Exit1 -> Update -> RTI
  task automatic finish_update();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [IR_W-1:0] op);
    goto_shift_ir();
    shift_bits("ir_capture", 32'(op), int'(IR_W), 32'h1, 1'b1);
    finish_update();
    check("ir_out", 128'(ir_out), 128'(op));
  endtask

  task automatic user_xfer(input int k, input logic [31:0] capv, input logic [31:0] din);
    logic [N_DR-1:0] oh;
    oh = N_DR'(1) << k;
    cap[k*DR_W +: DR_W] = capv;
    load_ir(IR_W'(UB + 32'(k)));
    check($sformatf("dr_select_ch%0d", k), 128'(dr_select), 128'(oh));
    goto_shift_dr();
    shift_bits($sformatf("user_ch%0d", k), din, int'(DR_W), capv, 1'b1);
    step(1'b1, 1'b0);
    check("pulse_before_update", 128'(dr_update_pulse), 128'(0));
    step(1'b0, 1'b0);
    exp_upd[k*DR_W +: DR_W] = din;
    check($sformatf("pulse_ch%0d", k), 128'(dr_update_pulse), 128'(oh));
    check($sformatf("upd_data_ch%0d", k), 128'(dr_update_data), 128'(exp_upd));
    step(1'b0, 1'b0);
    check("pulse_cleared", 128'(dr_update_pulse), 128'(0));
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] c1;
    cap = {$urandom, $urandom, $urandom, $urandom};
    exp_upd = '0;
    @(negedge TCK);

    // Reset
    TRST = 1'b0;
    step(1'b1, 1'b0);
    check("rst_state", 128'(state_out), 128'(4'hF));
    check("rst_ir", 128'(ir_out), 128'(ID_OP));
    check("rst_upd_data", 128'(dr_update_data), 128'(0));
    check("rst_pulse", 128'(dr_update_pulse), 128'(0));
    check("rst_tdo_en", 128'(tdo_en), 128'(0));
    TRST = 1'b1;
    step(1'b0, 1'b0);
    check("rti_state", 128'(state_out), 128'(4'hC));

    // IDCODE read
    goto_shift_dr();
    check("shift_dr_state", 128'(state_out), 128'(4'h2));
    check("shift_dr_tdo_en", 128'(tdo_en), 128'(1));
    shift_bits("idcode", 32'h0, 32, IDC, 1'b1);
    check("exit1_dr_state", 128'(state_out), 128'(4'h1));
    finish_update();
    check("idcode_no_pulse", 128'(dr_update_pulse), 128'(0));
    check("idcode_no_upd", 128'(dr_update_data), 128'(exp_upd));

    // IR capture pattern then BYPASS instruction
    goto_shift_ir();
    check("shift_ir_state", 128'(state_out), 128'(4'hA));
    shift_bits("ir_cap_ones", 32'h1F, 5, 32'h1, 1'b1);
    finish_update();
    check("ir_bypass", 128'(ir_out), 128'(5'h1F));
    check("sel_bypass", 128'(dr_select), 128'(0));

    // BYPASS: TDI 1,0,1,1 -> TDO 0,1,0,1
    goto_shift_dr();
    shift_bits("bypass", 32'b1101, 4, 32'b1010, 1'b1);
    finish_update();
    check("bypass_no_pulse", 128'(dr_update_pulse), 128'(0));

    // User channels, including first and last
    user_xfer(2, 32'hDEAD_BEEF, 32'h1234_5678);
    user_xfer(0, $urandom, $urandom);
    user_xfer(3, $urandom, $urandom);

    // Unknown opcode behaves as BYPASS
    load_ir(5'h03);
    check("sel_unknown", 128'(dr_select), 128'(0));
    goto_shift_dr();
    shift_bits("unknown_bypass", 32'b0110, 4, 32'b1100, 1'b1);
    finish_update();
    check("unknown_no_upd", 128'(dr_update_data), 128'(exp_upd));
    check("unknown_no_pulse", 128'(dr_update_pulse), 128'(0));

    // First opcode past the user range is BYPASS too
    load_ir(IR_W'(UB + N_DR));
    check("sel_past_range", 128'(dr_select), 128'(0));
    r = $urandom;
    goto_shift_dr();
    shift_bits("past_range_bypass", r, 8, {r[30:0], 1'b0}, 1'b1);
    finish_update();
    check("past_range_no_upd", 128'(dr_update_data), 128'(exp_upd));

    // IDCODE instruction explicitly reloaded
    load_ir(IR_W'(ID_OP));
    goto_shift_dr();
    shift_bits("idcode_again", $urandom, 32, IDC, 1'b1);
    finish_update();

    // TMS-only reset from Pause-DR keeps update registers
    load_ir(5'h1F);
    goto_shift_dr();
    shift_bits("bypass_to_pause", 32'b101, 3, 32'b010, 1'b1);
    step(1'b0, 1'b0);
    check("pause_dr_state", 128'(state_out), 128'(4'h3));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms_reset_state", 128'(state_out), 128'(4'hF));
    check("tms_reset_upd_kept", 128'(dr_update_data), 128'(exp_upd));
    step(1'b1, 1'b0);
    check("tlr_reload_ir", 128'(ir_out), 128'(ID_OP));
    check("tms_reset_no_pulse", 128'(dr_update_pulse), 128'(0));
    step(1'b0, 1'b0);

    // TRST in the middle of a channel 1 shift
    c1 = $urandom;
    cap[1*DR_W +: DR_W] = c1;
    load_ir(IR_W'(UB + 1));
    goto_shift_dr();
    r = $urandom;
    shift_bits("ch1_partial", r, 10, c1, 1'b0);
    check("mid_shift_state", 128'(state_out), 128'(4'h2));
    TRST = 1'b0;
    step(1'b0, 1'b0);
    exp_upd = '0;
    check("trst_state", 128'(state_out), 128'(4'hF));
    check("trst_ir", 128'(ir_out), 128'(ID_OP));
    check("trst_upd_cleared", 128'(dr_update_data), 128'(exp_upd));
    check("trst_pulse", 128'(dr_update_pulse), 128'(0));
    TRST = 1'b1;
    step(1'b0, 1'b0);
    check("rti_tdo_idle", 128'(TDO), 128'(0));
    goto_shift_dr();
    shift_bits("idcode_after_trst", 32'h0, 32, IDC, 1'b1);
    finish_update();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
